// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the memory-mapped countdown timer (Device 0):
//   - FSM state encoding (IDLE, LOAD, CNT, INT)
//   - register indices decoded from addr[3:2]
//   - MODE encodings and CTRL bit positions (including the prescale field
//     used when TIMER_PRESCALE_EN is defined)
//   - helper to classify the MODE field
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timerState_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM_BIT   = 3;
    localparam int unsigned CTRL_PS_LSB   = 4;
    localparam int unsigned CTRL_PS_MSB   = 11;

    localparam int unsigned PS_WIDTH = 8;

    // Only 01 reloads; 00, 10 and 11 all behave as one-shot.
    function automatic logic isReload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// 8-bit tick divider. On load it clears its counter and captures the divisor;
// while run is high it emits a tick every divisor+1 cycles. A divisor of 0
// therefore ticks on every run cycle.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   load    in  clear counter, capture divisor
//   run     in  count enable
//   divisor in  [PS_WIDTH-1:0] tick period minus one
//   tick    out one-cycle tick (combinational from registered state and run)
// -----------------------------------------------------------------------------
module timer_prescaler
    import timer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                run,
    input  logic [PS_WIDTH-1:0] divisor,
    output logic                tick
);

    logic [PS_WIDTH-1:0] divR;
    logic [PS_WIDTH-1:0] cntR;
    logic                wrapS;

    assign wrapS = (cntR == divR);
    assign tick  = run & wrapS;

    // Divisor capture and prescale counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divR <= {PS_WIDTH{1'b0}};
            cntR <= {PS_WIDTH{1'b0}};
        end else if (load) begin
            divR <= divisor;
            cntR <= {PS_WIDTH{1'b0}};
        end else if (run) begin
            if (wrapS) begin
                cntR <= {PS_WIDTH{1'b0}};
            end else begin
                cntR <= cntR + {{(PS_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            cntR <= cntR;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
// Memory-mapped countdown timer. Counts down from PRESET and raises irq in
// one-shot or auto-reload mode.
// Register map (addr[3:2]): 0 CTRL (EN bit0, MODE [2:1], IM bit3, PS [11:4]
// when TIMER_PRESCALE_EN is defined), 1 PRESET, 2 COUNT (read-only),
// 3 reserved (reads 0).
// Optional build macro: TIMER_PRESCALE_EN adds the PS field and a tick
// prescaler; when undefined the counter ticks every cycle.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   addr   in  [29:0] word address, only addr[3:2] decoded
//   we     in  write enable (already device-selected)
//   wdata  in  [WIDTH-1:0] write data
//   rdata  out [WIDTH-1:0] read data, combinational from addr[3:2]
//   irq    out registered interrupt request (pending & IM)
// -----------------------------------------------------------------------------
module timer_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [29:0]      addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    timerState_e      stateR, stateD;
    logic [WIDTH-1:0] countR, countD;
    logic [WIDTH-1:0] presetR, presetD;
    logic             enR, enD;
    logic [1:0]       modeR, modeD;
    logic             imR, imD;
    logic             pendingR, pendingD;
    logic             irqR, irqD;
    logic             enFsmS;
    logic             tickS;
    logic [1:0]       regIdxS;
    logic             wrCtrlS;
    logic             wrPresetS;
    logic [WIDTH-1:0] ctrlReadS;
    logic             unusedAddrBits;

    assign regIdxS        = addr[3:2];
    assign unusedAddrBits = ^{addr[29:4], addr[1:0]};
    assign wrCtrlS        = we & (regIdxS == REG_CTRL);
    assign wrPresetS      = we & (regIdxS == REG_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic [PS_WIDTH-1:0] psR, psD;

    // PS is captured by the prescaler at LOAD, so mid-count writes wait
    timer_prescaler uPrescaler (
        .clk     (clk),
        .reset   (reset),
        .load    (stateR == LOAD),
        .run     ((stateR == CNT) & enR),
        .divisor (psR),
        .tick    (tickS)
    );

    // PS field write path
    always_comb begin
        if (wrCtrlS) begin
            psD = wdata[CTRL_PS_MSB:CTRL_PS_LSB];
        end else begin
            psD = psR;
        end
    end

    // PS field storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psR <= {PS_WIDTH{1'b0}};
        end else begin
            psR <= psD;
        end
    end
`else
    assign tickS = 1'b1;
`endif

    // FSM next state, count update and FSM-side EN clear
    always_comb begin
        stateD = stateR;
        countD = countR;
        enFsmS = enR;
        case (stateR)
            IDLE: begin
                if (enR) begin
                    stateD = LOAD;
                end else begin
                    stateD = IDLE;
                end
            end
            LOAD: begin
                countD = presetR;
                stateD = CNT;
            end
            CNT: begin
                if (!enR) begin
                    stateD = IDLE;
                end else if (countR == {WIDTH{1'b0}}) begin
                    stateD = INT;
                end else if (tickS) begin
                    countD = countR - {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    countD = countR;
                end
            end
            INT: begin
                if (isReload(modeR)) begin
                    stateD = LOAD;
                end else begin
                    enFsmS = 1'b0;
                    stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Register writes; a CTRL write overrides the FSM EN clear and pending set
    always_comb begin
        if (wrCtrlS) begin
            enD      = wdata[CTRL_EN_BIT];
            modeD    = wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
            imD      = wdata[CTRL_IM_BIT];
            pendingD = 1'b0;
        end else begin
            enD   = enFsmS;
            modeD = modeR;
            imD   = imR;
            if ((stateR == CNT) && (stateD == INT)) begin
                pendingD = 1'b1;
            end else if ((stateR == INT) && isReload(modeR)) begin
                pendingD = 1'b0;
            end else begin
                pendingD = pendingR;
            end
        end
        if (wrPresetS) begin
            presetD = wdata;
        end else begin
            presetD = presetR;
        end
        irqD = pendingD & imD;
    end

    // Architectural state and registered interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR   <= IDLE;
            countR   <= {WIDTH{1'b0}};
            presetR  <= {WIDTH{1'b0}};
            enR      <= 1'b0;
            modeR    <= MODE_ONESHOT;
            imR      <= 1'b0;
            pendingR <= 1'b0;
            irqR     <= 1'b0;
        end else begin
            stateR   <= stateD;
            countR   <= countD;
            presetR  <= presetD;
            enR      <= enD;
            modeR    <= modeD;
            imR      <= imD;
            pendingR <= pendingD;
            irqR     <= irqD;
        end
    end

    assign irq = irqR;

    // CTRL read image; unimplemented bits read 0
    always_comb begin
        ctrlReadS                             = {WIDTH{1'b0}};
        ctrlReadS[CTRL_EN_BIT]                = enR;
        ctrlReadS[CTRL_MODE_MSB:CTRL_MODE_LSB] = modeR;
        ctrlReadS[CTRL_IM_BIT]                = imR;
`ifdef TIMER_PRESCALE_EN
        ctrlReadS[CTRL_PS_MSB:CTRL_PS_LSB]    = psR;
`endif
    end

    // Read mux
    always_comb begin
        case (regIdxS)
            REG_CTRL:   rdata = ctrlReadS;
            REG_PRESET: rdata = presetR;
            REG_COUNT:  rdata = countR;
            default:    rdata = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] addr = 30'd0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_PRESET = 2'd1;
    localparam logic [1:0] R_COUNT  = 2'd2;
    localparam logic [1:0] R_RSVD   = 2'd3;

    timer_counter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a write; it lands on the next rising edge.
    task automatic wr(input logic [1:0] idx, input logic [31:0] d);
        addr  = {26'd0, idx, 2'd0};
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] idx, output logic [31:0] d);
        addr = {26'd0, idx, 2'd0};
        #1;
        d = rdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        #2;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        for (int i = 0; i < 4; i++) begin
            rd(i[1:0], v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %0h expected 0", i, v); end
        end
        @(negedge clk);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_mid_count;
        logic [31:0] v;
        wr(R_PRESET, 32'd100);
        wr(R_CTRL, 32'h9);
        cyc(5);
        rd(R_COUNT, v);
        checks++;
        if (v !== 32'd97) begin errors++; $display("FAIL midrst_precount: got %0d expected 97", v); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %0b expected 0", irq); end
        for (int i = 0; i < 3; i++) begin
            rd(i[1:0], v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL midrst_reg%0d: got %0h expected 0", i, v); end
        end
        @(negedge clk);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        wr(R_PRESET, 32'd5);
        wr(R_CTRL, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            if (k >= 2) begin
                rd(R_COUNT, v);
                checks++;
                if (v !== ((k <= 7) ? 32'(7 - k) : 32'd0)) begin
                    errors++; $display("FAIL oneshot_count_e%0d: got %0d expected %0d", k, v, (k <= 7) ? (7 - k) : 0);
                end
            end
            checks++;
            if (irq !== (k == 8)) begin errors++; $display("FAIL oneshot_irq_e%0d: got %0b expected %0b", k, irq, (k == 8)); end
        end
        cyc(1);
        rd(R_CTRL, v);
        checks++;
        if (v !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl: got %0h expected 8", v); end
        cyc(2);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_hold: got %0b expected 1", irq); end
        wr(R_CTRL, 32'h8);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear: got %0b expected 0", irq); end
        cyc(2);
    endtask

    task automatic test_preset_zero;
        wr(R_PRESET, 32'd0);
        wr(R_CTRL, 32'h9);
        cyc(2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL pz_irq_e2: got %0b expected 0", irq); end
        cyc(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pz_irq_e3: got %0b expected 1", irq); end
        wr(R_CTRL, 32'h0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL pz_irq_clear: got %0b expected 0", irq); end
        cyc(3);
    endtask

    task automatic test_autoreload;
        wr(R_PRESET, 32'd3);
        wr(R_CTRL, 32'hB);
        for (int k = 1; k <= 19; k++) begin
            cyc(1);
            checks++;
            if (irq !== ((k % 6) == 0)) begin
                errors++; $display("FAIL reload_irq_e%0d: got %0b expected %0b", k, irq, ((k % 6) == 0));
            end
        end
        wr(R_CTRL, 32'h0);
        cyc(4);
    endtask

    task automatic test_mask_collision;
        logic [31:0] v;
        wr(R_PRESET, 32'd2);
        wr(R_CTRL, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_e%0d: got %0b expected 0", k, irq); end
        end
        rd(R_CTRL, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mask_ctrl: got %0h expected 0", v); end
        // Idle FSM must not pick up a new preset.
        wr(R_PRESET, 32'd9);
        cyc(3);
        rd(R_COUNT, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL mask_idle_count: got %0d expected 0", v); end
        // Collision: CTRL write lands on the edge leaving INT.
        wr(R_PRESET, 32'd2);
        wr(R_CTRL, 32'h9);
        cyc(4);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL coll_irq_pre: got %0b expected 0", irq); end
        cyc(1);
        wr(R_CTRL, 32'h9);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL coll_irq: got %0b expected 0", irq); end
        rd(R_CTRL, v);
        checks++;
        if (v !== 32'h9) begin errors++; $display("FAIL coll_ctrl: got %0h expected 9", v); end
        cyc(2);
        rd(R_COUNT, v);
        checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL coll_restart: got %0d expected 2", v); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL coll_irq_after: got %0b expected 0", irq); end
        wr(R_CTRL, 32'h0);
        cyc(4);
    endtask

    task automatic test_write_rules;
        logic [31:0] v;
        logic [31:0] ctrlExp;
        wr(R_PRESET, 32'd6);
        wr(R_CTRL, 32'h3);
        cyc(4);
        rd(R_COUNT, v);
        checks++;
        if (v !== 32'd4) begin errors++; $display("FAIL wr_count4: got %0d expected 4", v); end
        wr(R_PRESET, 32'd7);
        rd(R_COUNT, v);
        checks++;
        if (v !== 32'd3) begin errors++; $display("FAIL wr_count3: got %0d expected 3", v); end
        rd(R_PRESET, v);
        checks++;
        if (v !== 32'd7) begin errors++; $display("FAIL wr_preset: got %0d expected 7", v); end
        cyc(3);
        rd(R_COUNT, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL wr_count0: got %0d expected 0", v); end
        cyc(3);
        rd(R_COUNT, v);
        checks++;
        if (v !== 32'd7) begin errors++; $display("FAIL wr_reload7: got %0d expected 7", v); end
        wr(R_COUNT, 32'h55);
        rd(R_COUNT, v);
        checks++;
        if (v !== 32'd6) begin errors++; $display("FAIL wr_count_ro: got %0d expected 6", v); end
        wr(R_RSVD, 32'hFFFF_FFFF);
        rd(R_RSVD, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL wr_rsvd: got %0h expected 0", v); end
        rd(R_COUNT, v);
        checks++;
        if (v !== 32'd5) begin errors++; $display("FAIL wr_count5: got %0d expected 5", v); end
        wr(R_CTRL, 32'hFFFF_FFF0);
`ifdef TIMER_PRESCALE_EN
        ctrlExp = 32'hFF0;
`else
        ctrlExp = 32'h0;
`endif
        rd(R_CTRL, v);
        checks++;
        if (v !== ctrlExp) begin errors++; $display("FAIL wr_ctrl_upper: got %0h expected %0h", v, ctrlExp); end
        wr(R_CTRL, 32'h0);
        cyc(4);
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale;
        logic [31:0] v;
        logic [31:0] e;
        wr(R_PRESET, 32'd2);
        wr(R_CTRL, 32'h29);
        rd(R_CTRL, v);
        checks++;
        if (v !== 32'h29) begin errors++; $display("FAIL ps_ctrl: got %0h expected 29", v); end
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            if (k >= 2) begin
                e = (k < 5) ? 32'd2 : ((k < 8) ? 32'd1 : 32'd0);
                rd(R_COUNT, v);
                checks++;
                if (v !== e) begin errors++; $display("FAIL ps_count_e%0d: got %0d expected %0d", k, v, e); end
            end
            checks++;
            if (irq !== (k == 9)) begin errors++; $display("FAIL ps_irq_e%0d: got %0b expected %0b", k, irq, (k == 9)); end
        end
        wr(R_CTRL, 32'h0);
        cyc(4);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_mid_count();
        test_oneshot();
        test_preset_zero();
        test_autoreload();
        test_mask_collision();
        test_write_rules();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
